shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_pkg.sv | 22 ++
 rtl/shift_sequencer_stage_mux.sv | 67 ++++++
 rtl/shift_sequencer.sv | 101 ++++++++++
 tb/tb_shift_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared ALU shift definitions: operation encodings, sequencer states and data width.
package shift_sequencer_pkg;

    localparam int SEQ_WIDTH = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Stages are walked from the largest distance (16) down to 1.
    localparam logic [2:0] IDX_FIRST = 3'd4;

endpackage

// File: rtl/shift_sequencer_stage_mux.sv
// One shared power-of-two shift stage: shifts data by 2^idx per op when en, else passes data.
module shift_stage_mux
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  op_i,
    input  logic [2:0]  idx_i,
    input  logic        en_i,
    output logic [31:0] data_o
);

    logic [31:0] sll_v;
    logic [31:0] srl_v;
    logic [31:0] sra_v;

    // Fixed-distance wiring per stage; SRA replicates the currently held sign bit.
    always_comb begin
        sll_v = data_i;
        srl_v = data_i;
        sra_v = data_i;
        case (idx_i)
            3'd0: begin
                sll_v = {data_i[30:0], 1'b0};
                srl_v = {1'b0, data_i[31:1]};
                sra_v = {data_i[31], data_i[31:1]};
            end
            3'd1: begin
                sll_v = {data_i[29:0], 2'b00};
                srl_v = {2'b00, data_i[31:2]};
                sra_v = {{2{data_i[31]}}, data_i[31:2]};
            end
            3'd2: begin
                sll_v = {data_i[27:0], 4'h0};
                srl_v = {4'h0, data_i[31:4]};
                sra_v = {{4{data_i[31]}}, data_i[31:4]};
            end
            3'd3: begin
                sll_v = {data_i[23:0], 8'h00};
                srl_v = {8'h00, data_i[31:8]};
                sra_v = {{8{data_i[31]}}, data_i[31:8]};
            end
            3'd4: begin
                sll_v = {data_i[15:0], 16'h0000};
                srl_v = {16'h0000, data_i[31:16]};
                sra_v = {{16{data_i[31]}}, data_i[31:16]};
            end
            default: begin
                sll_v = data_i;
                srl_v = data_i;
                sra_v = data_i;
            end
        endcase
    end

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                SHIFT_SLL: data_o = sll_v;
                SHIFT_SRL: data_o = srl_v;
                SHIFT_SRA: data_o = sra_v;
                default:   data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: five shared-stage passes (16,8,4,2,1), one per clock.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [4:0]       shamt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    // Handshake: a shift is accepted on an edge with start && in_ready && !flush; the
    // result is taken on an edge with out_valid && out_ready. in_ready/out_valid come
    // from registered state only; flush returns to IDLE and drops any pending result.

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [2:0]  idx_q, idx_d;

    logic [7:0]  shamt_ext;
    logic        stage_en;
    logic [31:0] stage_out;

    assign shamt_ext = {3'b000, shamt_q};
    assign stage_en  = shamt_ext[idx_q];

    shift_stage_mux u_stage (
        .data_i (work_q),
        .op_i   (op_q),
        .idx_i  (idx_q),
        .en_i   (stage_en),
        .data_o (stage_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_d  = A;
                        op_d    = op;
                        shamt_d = shamt;
                        idx_d   = IDX_FIRST;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_d = stage_out;
                    idx_d  = idx_q - 3'd1;
                    if (idx_q == 3'd0) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed, randomized, backpressure, flush and reset scenarios.
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    shift_sequencer #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the whole shift done at once with plain operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
        case (o)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return $unsigned($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    // Waits for in_ready, presents one request for a single cycle, then scrambles the operands.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        start = 1'b1;
        op    = o;
        A     = a;
        shamt = s;
        @(negedge clock);
        start = 1'b0;
        A     = $urandom;
        op    = 2'($urandom_range(0, 3));
        shamt = 5'($urandom_range(0, 31));
    endtask

    // From the negedge after the accept edge: out_valid low through E4, high after E5.
    task automatic run_latency(input string name, output logic [31:0] exp_v);
        exp_v = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_early_valid: cycle %0d out_valid=%b required 0", name, k, out_valid);
            end
            @(negedge clock);
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_latency: out_valid=%b required 1", name, out_valid);
        end
        vectors++;
        if (result !== exp_v) begin
            miscompares++;
            $display("FAIL %s_result: got %h required %h", name, result, exp_v);
        end
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_take: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 2'd0; A = '0; shamt = '0;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h required 1/0/0", in_ready, out_valid, result);
        end
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b result=%h required 1/0/0", in_ready, out_valid, result);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  d_op [6] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3};
        logic [31:0] d_a  [6] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFF0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [4:0]  d_s  [6] = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd0, 5'd31};
        logic [31:0] d_r  [6] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                                  32'h07FF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(d_r[i]);
            issue(d_op[i], d_a[i], d_s[i]);
            run_latency("directed", e);
            take("directed");
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] e;
        int stall;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            exp_q.push_back(ref_shift(o, a, int'(s)));
            issue(o, a, s);
            run_latency("random", e);
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(negedge clock);
                vectors++;
                if (out_valid !== 1'b1 || result !== e) begin
                    miscompares++;
                    $display("FAIL random_hold: out_valid=%b result=%h required 1/%h", out_valid, result, e);
                end
            end
            take("random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        exp_q.push_back(32'h0800_0000);
        issue(2'd1, 32'h8000_0000, 5'd4);
        run_latency("bp", e);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            A         = $urandom;
            @(negedge clock);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e) begin
                miscompares++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b result=%h required 1/0/%h",
                         out_valid, in_ready, result, e);
            end
        end
        start = 1'b0;
        take("bp");
        @(negedge clock);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_start_ignored: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        logic [1:0]  o = 2'($urandom_range(0, 3));
        logic [31:0] a = $urandom;
        logic [4:0]  s = 5'($urandom_range(0, 31));
        logic [31:0] partial;
        // Flushed after the 16 and 8 stages: work holds the shift by the upper shamt bits.
        partial = ref_shift(o, a, int'(s & 5'b11000));
        issue(o, a, s);
        @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        vectors++;
        if (result !== partial) begin
            miscompares++;
            $display("FAIL flush_work: got %h required %h", result, partial);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_result: out_valid=%b required 0", out_valid);
            end
        end
        start = 1'b1;
        flush = 1'b1;
        A     = 32'h1234_5678;
        op    = 2'd0;
        shamt = 5'd3;
        @(negedge clock);
        start = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_start_rejected: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        issue(2'd0, 32'h0000_FFFF, 5'd3);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_shift: in_ready=%b out_valid=%b result=%h required 1/0/0", in_ready, out_valid, result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(32'h0000_0F00);
        issue(2'd1, 32'h0000_F000, 5'd4);
        run_latency("areset_pre", e);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_done: in_ready=%b out_valid=%b result=%h required 1/0/0", in_ready, out_valid, result);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        exp_q.push_back(32'h0000_0002);
        issue(2'd0, 32'h0000_0001, 5'd1);
        run_latency("areset_post", e);
        take("areset_post");
    endtask

    task automatic test_back_to_back();
        logic [31:0] e = 32'h0787_8000;
        int cycles;
        out_ready = 1'b1;
        start     = 1'b1;
        op        = 2'd1;
        A         = 32'hF0F0_0000;
        shamt     = 5'd5;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        vectors++;
        if (out_valid !== 1'b1 || result !== e) begin
            miscompares++;
            $display("FAIL b2b_first: out_valid=%b result=%h required 1/%h", out_valid, result, e);
        end
        for (int n = 0; n < 3; n++) begin
            cycles = 0;
            do begin
                @(negedge clock);
                cycles++;
            end while (out_valid !== 1'b1 && cycles < 20);
            vectors++;
            if (cycles != 7 || result !== e) begin
                miscompares++;
                $display("FAIL b2b_interval: cycles=%0d result=%h required 7/%h", cycles, result, e);
            end
        end
        start = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
